// File: rtl/arith_pkg.sv
// Shared constants and types for the multi-cycle wide arithmetic datapath.
// Holds operand/slice widths, slice count, slice-index width and FSM states.
package arith_pkg;

    localparam int WIDTH  = 256;
    localparam int CHUNK  = 32;
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sub_chunk.sv
// Combinational W-bit subtract-with-borrow slice: d = a - b - bi, bo = borrow.
// Ports: a, b (W), bi (1) in; d (W), bo (1) out.
module sub_chunk
    import arith_pkg::*;
#(
    parameter int W = CHUNK
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bi,
    output logic [W-1:0] d,
    output logic         bo
);

    logic [W:0] res;

    // Widened by one bit: the MSB of the wrapped result is the borrow-out.
    always_comb begin
        res = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
        d   = res[W-1:0];
        bo  = res[W];
    end

endmodule

// File: rtl/subtractor_256bit.sv
// Multi-cycle WIDTH-bit subtractor, one CHUNK slice per cycle, LSB first.
// Ports: clk, rst (sync, high), start, din_one (A), din_two (B), bin in;
//        diff, bout, busy, done (1-cycle pulse) out.
module subtractor_256bit
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din_one,
    input  logic [WIDTH-1:0] din_two,
    input  logic             bin,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             busy,
    output logic             done
);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               brw_q, brw_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic               bout_q, bout_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [CHUNK-1:0]   a_sl;
    logic [CHUNK-1:0]   b_sl;
    logic [CHUNK-1:0]   d_sl;
    logic               bo_sl;

    always_comb begin
        a_sl = a_q[int'(idx_q)*CHUNK +: CHUNK];
        b_sl = b_q[int'(idx_q)*CHUNK +: CHUNK];
    end

    sub_chunk #(
        .W (CHUNK)
    ) u_sub_chunk (
        .a  (a_sl),
        .b  (b_sl),
        .bi (brw_q),
        .d  (d_sl),
        .bo (bo_sl)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        brw_d   = brw_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = din_one;
                    b_d     = din_two;
                    brw_d   = bin;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                diff_d[int'(idx_q)*CHUNK +: CHUNK] = d_sl;
                brw_d = bo_sl;
                idx_d = idx_q + 1'b1;
                if (idx_q == IDX_W'(NCHUNK - 1)) begin
                    bout_d  = bo_sl;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    idx_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            brw_q   <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            brw_q   <= brw_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_subtractor_256bit.sv
// Self-checking bench for subtractor_256bit.
// Scoreboard queue of expected results, popped and compared on done.
module tb_subtractor_256bit;
    import arith_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] din_one;
    logic [WIDTH-1:0] din_two;
    logic             bin;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    subtractor_256bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .din_one (din_one),
        .din_two (din_two),
        .bin     (bin),
        .diff    (diff),
        .bout    (bout),
        .busy    (busy),
        .done    (done)
    );

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             b;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic exp_t model(input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b,
                                   input logic bi);
        logic [WIDTH:0] r;
        exp_t e;
        r   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bi};
        e.d = r[WIDTH-1:0];
        e.b = r[WIDTH];
        return e;
    endfunction

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b,
                         input logic bi);
        din_one = a;
        din_two = b;
        bin     = bi;
        start   = 1'b1;
        sb.push_back(model(a, b, bi));
    endtask

    // lat = negedges until done seen; accept-to-done cycles is lat-1.
    task automatic wait_done(output int lat, output int bcnt, output bit ok);
        lat  = 0;
        bcnt = 0;
        ok   = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) bcnt++;
            if (done) begin
                lat = c;
                ok  = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        exp_t e;
        rst   = 1'b1;
        start = 1'b1;
        din_one = '1;
        din_two = '0;
        @(negedge clk);
        @(negedge clk);
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got=%b want=0", done);
        end
        n_tests++;
        if (diff !== '0) begin
            n_fail++;
            $display("FAIL reset_diff got=%h want=0", diff);
        end
        n_tests++;
        if (bout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bout got=%b want=0", bout);
        end
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        e.d = '0;
    endtask

    task automatic test_vectors();
        logic [WIDTH-1:0] ta[4];
        logic [WIDTH-1:0] tb[4];
        logic             tbi[4];
        logic [WIDTH-1:0] td[4];
        logic             tbo[4];
        int   lat, bcnt;
        bit   ok;
        exp_t e;
        ta[0] = '0;   tb[0] = '0;   tbi[0] = 1'b0; td[0] = '0; tbo[0] = 1'b0;
        ta[1] = 'hff; tb[1] = 'hff; tbi[1] = 1'b1; td[1] = '1; tbo[1] = 1'b1;
        ta[2] = '0;   ta[2][32] = 1'b1;
        tb[2] = 'd1;  tbi[2] = 1'b0;
        td[2] = 'hffff_ffff; tbo[2] = 1'b0;
        ta[3] = '0;   tb[3] = 'd1;  tbi[3] = 1'b0; td[3] = '1; tbo[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], tbi[i]);
            wait_done(lat, bcnt, ok);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL vec%0d_timeout no done within 20 cycles", i);
                void'(sb.pop_front());
                continue;
            end
            e = sb.pop_front();
            n_tests++;
            if (lat - 1 !== NCHUNK) begin
                n_fail++;
                $display("FAIL vec%0d_latency got=%0d want=%0d", i, lat - 1, NCHUNK);
            end
            n_tests++;
            if (bcnt !== NCHUNK) begin
                n_fail++;
                $display("FAIL vec%0d_busy_cycles got=%0d want=%0d", i, bcnt, NCHUNK);
            end
            n_tests++;
            if (diff !== td[i] || diff !== e.d) begin
                n_fail++;
                $display("FAIL vec%0d_diff got=%h want=%h", i, diff, td[i]);
            end
            n_tests++;
            if (bout !== tbo[i] || bout !== e.b) begin
                n_fail++;
                $display("FAIL vec%0d_bout got=%b want=%b", i, bout, tbo[i]);
            end
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL vec%0d_done_pulse got=%b want=0", i, done);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        int   lat, bcnt;
        bit   ok;
        exp_t e;
        issue(WIDTH'(5), WIDTH'(3), 1'b0);
        lat = 0;
        ok  = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                ok  = 1'b1;
                break;
            end
            if (c == 3) begin
                din_one = WIDTH'(9);
                din_two = WIDTH'(1);
                start   = 1'b1;
            end
        end
        e = sb.pop_front();
        n_tests++;
        if (!ok || lat - 1 !== NCHUNK) begin
            n_fail++;
            $display("FAIL ignore_latency got=%0d want=%0d", lat - 1, NCHUNK);
        end
        n_tests++;
        if (diff !== e.d || diff !== WIDTH'(2)) begin
            n_fail++;
            $display("FAIL ignore_diff got=%h want=2", diff);
        end
        // Start held during the done cycle is accepted immediately.
        issue(WIDTH'(9), WIDTH'(1), 1'b0);
        wait_done(lat, bcnt, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || lat !== NCHUNK + 1) begin
            n_fail++;
            $display("FAIL b2b_spacing got=%0d want=%0d", lat, NCHUNK + 1);
        end
        n_tests++;
        if (diff !== e.d || diff !== WIDTH'(8)) begin
            n_fail++;
            $display("FAIL b2b_diff got=%h want=8", diff);
        end
        n_tests++;
        if (bout !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_bout got=%b want=0", bout);
        end
    endtask

    task automatic test_reset_mid_run();
        int   lat, bcnt, ndone;
        bit   ok;
        exp_t e;
        din_one = '1;
        din_two = '0;
        bin     = 1'b0;
        start   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_tests++;
        if (diff === '0) begin
            n_fail++;
            $display("FAIL midrun_partial got=%h want=nonzero", diff);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if (diff !== '0 || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_rst_out got=%h/%b want=0/0", diff, bout);
        end
        n_tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_rst_flags got=%b/%b want=0/0", busy, done);
        end
        ndone = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        n_tests++;
        if (ndone !== 0) begin
            n_fail++;
            $display("FAIL midrun_no_done got=%0d want=0", ndone);
        end
        issue(WIDTH'(7), WIDTH'(3), 1'b1);
        wait_done(lat, bcnt, ok);
        e = sb.pop_front();
        n_tests++;
        if (!ok || diff !== e.d || diff !== WIDTH'(3) || bout !== 1'b0) begin
            n_fail++;
            $display("FAIL after_rst_op got=%h/%b want=3/0", diff, bout);
        end
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] a, b;
        logic             bi;
        int   lat, bcnt;
        bit   ok;
        exp_t e;
        for (int i = 0; i < 6; i++) begin
            for (int w = 0; w < WIDTH / 32; w++) begin
                a[w*32 +: 32] = $urandom;
                b[w*32 +: 32] = $urandom;
            end
            if (i == 0) b = a;
            bi = 1'($urandom_range(0, 1));
            issue(a, b, bi);
            wait_done(lat, bcnt, ok);
            e = sb.pop_front();
            n_tests++;
            if (!ok || diff !== e.d || bout !== e.b) begin
                n_fail++;
                $display("FAIL rand%0d got=%h/%b want=%h/%b",
                         i, diff, bout, e.d, e.b);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        bin     = 1'b0;
        din_one = '0;
        din_two = '0;
        @(negedge clk);
        test_reset();
        test_vectors();
        test_ignore_and_back_to_back();
        test_reset_mid_run();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
